// File: rtl/spi_cmd_parser.sv
// SPI command parser: decodes command byte + DATA_BYTES data bytes into register
// write/read strobes and serves the read word back one byte at a time on response_data.
module spi_cmd_parser #(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rec_data,
  input  logic                    rec_done,
  input  logic                    cs_n,
  output logic [7:0]              response_data,
  output logic [6:0]              reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wr_data,
  output logic                    reg_wr_en,
  output logic                    reg_rd_en,
  input  logic [8*DATA_BYTES-1:0] reg_rd_data,
  output logic                    frame_err
);

  localparam int unsigned W = 8 * DATA_BYTES;
  localparam logic [2:0] LastIdx = 3'(DATA_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StWdata, StRdata, StHold} state_e;

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [6:0]   addr_q, addr_d;
  logic [W-1:0] wr_data_q, wr_data_d;
  logic [W-1:0] rd_shift_q, rd_shift_d;
  logic         wr_en_q, wr_en_d;
  logic         rd_en_q, rd_en_d;
  logic         err_q, err_d;
  logic         load_q, load_d;
  logic         last_byte;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      rd_shift_q <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_q      <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rd_shift_q <= rd_shift_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      err_q      <= err_d;
      load_q     <= load_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_d     = 1'b0;
    // Read word arrives the cycle after reg_rd_en; capture it then.
    load_d     = rd_en_q;
    rd_shift_d = load_q ? reg_rd_data : rd_shift_q;
    last_byte  = rec_done && (cnt_q == LastIdx);

    case (state_q)
      StIdle: begin
        if (rec_done && !cs_n) begin
          addr_d     = rec_data[6:0];
          cnt_d      = '0;
          rd_shift_d = '0;
          rd_en_d    = !rec_data[7];
          state_d    = rec_data[7] ? StWdata : StRdata;
        end
      end
      StWdata: begin
        if (rec_done) begin
          wr_data_d = (wr_data_q << 8) | W'(rec_data);
          cnt_d     = cnt_q + 3'd1;
        end
        // A byte that completes the frame wins over a coincident cs_n release.
        if (last_byte) begin
          state_d = StHold;
          wr_en_d = 1'b1;
        end else if (cs_n) begin
          err_d = 1'b1;
        end
      end
      StRdata: begin
        if (rec_done) begin
          rd_shift_d = rd_shift_d << 8;
          cnt_d      = cnt_q + 3'd1;
        end
        if (last_byte) begin
          state_d = StHold;
        end else if (cs_n) begin
          err_d = 1'b1;
        end
      end
      StHold: ;
      default: state_d = StIdle;
    endcase

    if (cs_n) state_d = StIdle;
  end

  // While the capture is pending the incoming word is forwarded so the first byte is
  // ready two cycles after the command byte.
  always_comb begin
    response_data = 8'h00;
    if (state_q == StRdata) begin
      response_data = load_q ? reg_rd_data[W-1 -: 8] : rd_shift_q[W-1 -: 8];
    end
  end

  assign reg_addr    = addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_rd_en   = rd_en_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Self-checking bench for spi_cmd_parser: table of whole frames plus directed
// abort / overrun / coincident-edge / reset sequences.
module tb_spi_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rec_data = 8'h00;
  logic        rec_done = 1'b0;
  logic        cs_n = 1'b1;
  logic [7:0]  response_data;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data = 32'h0;
  logic        frame_err;
  logic [31:0] rd_word = 32'h0;

  int n_cmp = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int overlap = 0;
  logic post_wr, post_rd, post_err;

  always #5 clk = ~clk;

  spi_cmd_parser #(.DATA_BYTES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rec_data     (rec_data),
    .rec_done     (rec_done),
    .cs_n         (cs_n),
    .response_data(response_data),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_data  (reg_rd_data),
    .frame_err    (frame_err)
  );

  // Register file model: read word valid only in the cycle after reg_rd_en.
  always @(posedge clk) begin
    reg_rd_data <= reg_rd_en ? rd_word : 32'h0BAD_F00D;
    if (reg_wr_en) wr_cnt <= wr_cnt + 1;
    if (reg_rd_en) rd_cnt <= rd_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (int'(reg_wr_en) + int'(reg_rd_en) + int'(frame_err) > 1) overlap <= overlap + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulses rec_done for one cycle; strobes are captured one cycle after it.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rec_data = b;
    rec_done = 1'b1;
    @(negedge clk);
    rec_done = 1'b0;
    post_wr  = reg_wr_en;
    post_rd  = reg_rd_en;
    post_err = frame_err;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] data;     // write payload or read word supplied by the model
    logic [6:0]  exp_addr;
    logic [31:0] exp_wr;
    logic [31:0] exp_resp; // response bytes expected before data bytes 1..4
  } vec_t;

  vec_t vecs[6];

  task automatic run_frame(input vec_t v, input int idx);
    int w0, r0, e0;
    logic is_wr;
    is_wr = v.cmd[7];
    rd_word = v.data;
    @(negedge clk);
    cs_n = 1'b0;
    idle(1);
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    send_byte(v.cmd);
    check($sformatf("v%0d rd_en after cmd", idx), 32'(post_rd), 32'(!is_wr));
    if (!is_wr) begin
      @(negedge clk);
      check($sformatf("v%0d first resp at +2", idx), 32'(response_data), 32'(v.exp_resp[31:24]));
    end
    for (int i = 0; i < 4; i++) begin
      idle(2);
      if (!is_wr)
        check($sformatf("v%0d resp byte %0d", idx, i), 32'(response_data),
              32'(v.exp_resp[31-8*i -: 8]));
      send_byte(is_wr ? v.data[31-8*i -: 8] : 8'h5A);
      check($sformatf("v%0d wr_en after byte %0d", idx, i), 32'(post_wr),
            32'(is_wr && i == 3));
    end
    idle(2);
    check($sformatf("v%0d resp in hold", idx), 32'(response_data), 32'h0);
    check($sformatf("v%0d addr", idx), 32'(reg_addr), 32'(v.exp_addr));
    check($sformatf("v%0d wr_data", idx), reg_wr_data, v.exp_wr);
    cs_n = 1'b1;
    idle(2);
    check($sformatf("v%0d wr_en count", idx), 32'(wr_cnt - w0), 32'(is_wr));
    check($sformatf("v%0d rd_en count", idx), 32'(rd_cnt - r0), 32'(!is_wr));
    check($sformatf("v%0d frame_err count", idx), 32'(err_cnt - e0), 32'h0);
  endtask

  initial begin
    int w0, r0, e0;
    vecs[0] = '{cmd: 8'h85, data: 32'h12345678, exp_addr: 7'h05, exp_wr: 32'h12345678, exp_resp: 32'h0};
    vecs[1] = '{cmd: 8'h0A, data: 32'hDEADBEEF, exp_addr: 7'h0A, exp_wr: 32'h12345678, exp_resp: 32'hDEADBEEF};
    vecs[2] = '{cmd: 8'hFF, data: 32'hA5C30F96, exp_addr: 7'h7F, exp_wr: 32'hA5C30F96, exp_resp: 32'h0};
    vecs[3] = '{cmd: 8'h00, data: 32'h01028001, exp_addr: 7'h00, exp_wr: 32'hA5C30F96, exp_resp: 32'h01028001};
    vecs[4] = '{cmd: 8'h80, data: 32'h00000000, exp_addr: 7'h00, exp_wr: 32'h00000000, exp_resp: 32'h0};
    vecs[5] = '{cmd: 8'h7F, data: 32'hFFFFFFFF, exp_addr: 7'h7F, exp_wr: 32'h00000000, exp_resp: 32'hFFFFFFFF};

    // Reset state
    idle(3);
    check("reset response", 32'(response_data), 32'h0);
    check("reset addr", 32'(reg_addr), 32'h0);
    check("reset wr_data", reg_wr_data, 32'h0);
    check("reset strobes", {29'h0, reg_wr_en, reg_rd_en, frame_err}, 32'h0);
    rst = 1'b1;
    idle(2);

    for (int k = 0; k < 6; k++) run_frame(vecs[k], k);

    // rec_done with cs_n high in IDLE is ignored
    r0 = rd_cnt;
    send_byte(8'h33);
    idle(2);
    check("idle cs_n=1 rd_en count", 32'(rd_cnt - r0), 32'h0);
    check("idle cs_n=1 addr", 32'(reg_addr), 32'h7F);

    // Abort mid write frame
    @(negedge clk); cs_n = 1'b0;
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h81); send_byte(8'hAA); send_byte(8'hBB);
    idle(1);
    cs_n = 1'b1;
    @(negedge clk);
    check("abort frame_err pulse", 32'(frame_err), 32'h1);
    idle(3);
    check("abort frame_err count", 32'(err_cnt - e0), 32'h1);
    check("abort wr_en count", 32'(wr_cnt - w0), 32'h0);
    cs_n = 1'b0;
    idle(1);
    send_byte(8'h01);
    check("abort back in idle", 32'(post_rd), 32'h1);
    cs_n = 1'b1;
    idle(3);

    // Overrun: extra bytes in HOLD are ignored
    cs_n = 1'b0;
    idle(1);
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h85);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("overrun wr_en on 4th byte", 32'(post_wr), 32'h1);
    send_byte(8'h99);
    check("overrun extra byte 1 strobe", 32'(post_wr | post_rd), 32'h0);
    send_byte(8'h88);
    check("overrun extra byte 2 strobe", 32'(post_wr | post_rd), 32'h0);
    idle(1);
    check("overrun wr_data", reg_wr_data, 32'h11223344);
    cs_n = 1'b1;
    idle(3);
    check("overrun wr_en count", 32'(wr_cnt - w0), 32'h1);
    check("overrun frame_err count", 32'(err_cnt - e0), 32'h0);

    // Last write byte coincident with cs_n release
    cs_n = 1'b0;
    idle(1);
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h82);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    @(negedge clk);
    rec_data = 8'hC4; rec_done = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    rec_done = 1'b0;
    check("edge wr_en", 32'(reg_wr_en), 32'h1);
    check("edge frame_err", 32'(frame_err), 32'h0);
    idle(3);
    check("edge wr_en count", 32'(wr_cnt - w0), 32'h1);
    check("edge frame_err count", 32'(err_cnt - e0), 32'h0);
    check("edge wr_data", reg_wr_data, 32'hC1C2C3C4);
    check("edge addr", 32'(reg_addr), 32'h02);

    // Reset after second data byte, then a fresh frame
    cs_n = 1'b0;
    idle(1);
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h81); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("mid reset addr", 32'(reg_addr), 32'h0);
    check("mid reset wr_data", reg_wr_data, 32'h0);
    check("mid reset response", 32'(response_data), 32'h0);
    check("mid reset strobes", {29'h0, reg_wr_en, reg_rd_en, frame_err}, 32'h0);
    rst = 1'b1;
    send_byte(8'h83);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("post reset wr_en", 32'(post_wr), 32'h1);
    idle(1);
    check("post reset wr_data", reg_wr_data, 32'h01020304);
    check("post reset addr", 32'(reg_addr), 32'h03);
    cs_n = 1'b1;
    idle(3);
    check("post reset wr_en count", 32'(wr_cnt - w0), 32'h1);
    check("post reset frame_err count", 32'(err_cnt - e0), 32'h0);

    check("strobe overlap cycles", 32'(overlap), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
